// File: rtl/gray_downscale_2x2.sv
// gray_downscale_2x2: streaming 2x2 rounded box-filter decimator for a luminance stream
module gray_downscale_2x2 #(
  parameter int IMAGE_HEIGHT = 480,
  parameter int IMAGE_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 510,
  parameter int FRAME_WIDTH  = 784,
  localparam int V_BITW = $clog2(FRAME_HEIGHT),
  localparam int H_BITW = $clog2(FRAME_WIDTH)
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic [7:0]        in_y,
  input  logic [V_BITW-1:0] in_vcnt,
  input  logic [H_BITW-1:0] in_hcnt,
  output logic [7:0]        out_y,
  output logic [V_BITW-1:0] out_vcnt,
  output logic [H_BITW-1:0] out_hcnt,
  output logic              out_valid
);
  localparam int AW = $clog2(IMAGE_WIDTH / 2);
  logic [7:0]        y1, hold;
  logic [V_BITW-1:0] v1;
  logic [H_BITW-1:0] h1;
  logic              a1, row_ok, row_started, active;
  logic [8:0]        mem [IMAGE_WIDTH / 2];
  logic [8:0]        rd, hsum;
  logic [9:0]        rnd;
  assign active = (in_vcnt < V_BITW'(IMAGE_HEIGHT)) && (in_hcnt < H_BITW'(IMAGE_WIDTH));
  assign hsum   = 9'(hold) + 9'(y1);
  assign rnd    = 10'(rd) + 10'(hsum) + 10'd2;
  // Line buffer of even-row horizontal pair sums; the read is aligned with stage 1.
  always_ff @(posedge clock) begin
    if (a1 && h1[0] && !v1[0]) mem[AW'(h1 >> 1)] <= hsum;
    if (in_hcnt < H_BITW'(IMAGE_WIDTH)) rd <= mem[AW'(in_hcnt >> 1)];
  end
  // Stage-1 capture, pair accumulation, row qualification and registered outputs.
  always_ff @(posedge clock) begin
    if (!n_rst) begin
      y1          <= '0;
      v1          <= '0;
      h1          <= '0;
      a1          <= 1'b0;
      hold        <= '0;
      row_ok      <= 1'b0;
      row_started <= 1'b0;
      out_y       <= '0;
      out_vcnt    <= '0;
      out_hcnt    <= '0;
      out_valid   <= 1'b0;
    end else begin
      y1        <= in_y;
      v1        <= in_vcnt;
      h1        <= in_hcnt;
      a1        <= active;
      out_valid <= 1'b0;
      if (a1 && !h1[0]) hold <= y1;
      if (a1 && !v1[0] && h1 == '0) begin
        row_started <= 1'b1;
        row_ok      <= 1'b0;
      end
      if (a1 && !v1[0] && h1 == H_BITW'(IMAGE_WIDTH - 1) && row_started) begin
        row_ok      <= 1'b1;
        row_started <= 1'b0;
      end
      if (a1 && v1[0] && h1[0] && row_ok) begin
        out_y     <= rnd[9:2];
        out_vcnt  <= v1 >> 1;
        out_hcnt  <= h1 >> 1;
        out_valid <= 1'b1;
      end
    end
  end
endmodule
